// File: rtl/pc_seq_unit.sv
// Registered next-PC / status / return-address-stack unit for the SEQ Y86-64 core.
// Optional build macro PC_RETIRE_CNT_EN enables the committed-update counter on retire_cnt.
//
// state   | meaning
// ST_RUN  | executing; committing cycles update pc, RAS and retire count
// ST_HLT  | halt instruction committed; frozen until rst
// ST_INS  | invalid icode committed; frozen until rst
module pc_seq_unit #(
    parameter int                 ADDR_W    = 64,
    parameter int                 RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         cnd,
    input  logic [3:0]                   icode,
    input  logic [ADDR_W-1:0]            valC,
    input  logic [ADDR_W-1:0]            valM,
    input  logic [ADDR_W-1:0]            valP,
    output logic [ADDR_W-1:0]            pc,
    output logic [1:0]                   stat,
    output logic                         ras_mispred,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic [31:0]                  retire_cnt
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_HLT = 2'd1,
        ST_INS = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [PTR_W-1:0]       ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0]       ras_cnt_q, ras_cnt_d;
    logic                   mispred_q, mispred_d;
    logic [ADDR_W-1:0]      ras_mem_q [RAS_DEPTH];

    logic [ADDR_W-1:0]      next_pc;
    logic [PTR_W-1:0]       ras_top;
    logic                   commit;
    logic                   ras_push;

    always_comb begin
        next_pc = valP;
        case (icode)
            4'd7:    next_pc = cnd ? valC : valP;
            4'd8:    next_pc = valC;
            4'd9:    next_pc = valM;
            default: next_pc = valP;
        endcase
    end

    assign commit   = (state_q == ST_RUN) && !stall;
    assign ras_push = commit && (icode == 4'd8);
    assign ras_top  = ras_ptr_q - PTR_W'(1);

`ifdef PC_RETIRE_CNT_EN
    logic [31:0] retire_q, retire_d;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        mispred_d = 1'b0;
`ifdef PC_RETIRE_CNT_EN
        retire_d  = retire_q;
`endif
        if (commit) begin
            if (icode == 4'd0) begin
                state_d = ST_HLT;
            end else if (icode > 4'd11) begin
                state_d = ST_INS;
            end else begin
                pc_d = next_pc;
`ifdef PC_RETIRE_CNT_EN
                retire_d = retire_q + 32'd1;
`endif
                if (icode == 4'd8) begin
                    ras_ptr_d = ras_ptr_q + PTR_W'(1);
                    if (ras_cnt_q != CNT_W'(RAS_DEPTH))
                        ras_cnt_d = ras_cnt_q + CNT_W'(1);
                end else if (icode == 4'd9) begin
                    // The RAS only flags disagreement; pc always follows valM.
                    if (ras_cnt_q != '0) begin
                        mispred_d = (ras_mem_q[ras_top] != valM);
                        ras_ptr_d = ras_top;
                        ras_cnt_d = ras_cnt_q - CNT_W'(1);
                    end else begin
                        mispred_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            mispred_q <= 1'b0;
`ifdef PC_RETIRE_CNT_EN
            retire_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            mispred_q <= mispred_d;
`ifdef PC_RETIRE_CNT_EN
            retire_q  <= retire_d;
`endif
            if (ras_push)
                ras_mem_q[ras_ptr_q] <= valP;
        end
    end

    assign pc          = pc_q;
    assign stat        = state_q;
    assign ras_mispred = mispred_q;
    assign ras_count   = ras_cnt_q;
`ifdef PC_RETIRE_CNT_EN
    assign retire_cnt  = retire_q;
`else
    assign retire_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        rst, stall, cnd;
    logic [3:0]  icode;
    logic [63:0] valC, valM, valP;
    logic [63:0] pc;
    logic [1:0]  stat;
    logic        ras_mispred;
    logic [3:0]  ras_count;
    logic [31:0] retire_cnt;

    pc_seq_unit #(.ADDR_W(64), .RAS_DEPTH(8), .RESET_PC(64'h100)) dut (
        .clk(clk), .rst(rst), .stall(stall), .cnd(cnd), .icode(icode),
        .valC(valC), .valM(valM), .valP(valP), .pc(pc), .stat(stat),
        .ras_mispred(ras_mispred), .ras_count(ras_count), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [1:0]  stat;
        logic        mis;
        logic [3:0]  cnt;
        logic [31:0] ret;
    } exp_t;

    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_ret = 0;
    int          step_no = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, step_no, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",          pc,                 e.pc);
                chk("stat",        {62'd0, stat},      {62'd0, e.stat});
                chk("ras_mispred", {63'd0, ras_mispred}, {63'd0, e.mis});
                chk("ras_count",   {60'd0, ras_count}, {60'd0, e.cnt});
                chk("retire_cnt",  {32'd0, retire_cnt}, {32'd0, e.ret});
                step_no++;
            end
        end
    end

    // Called at a negedge: drive, let one rising edge pass, then queue the expected result.
    task automatic step(input logic r, input logic s, input logic c, input logic [3:0] ic,
                        input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp,
                        input logic [63:0] e_pc, input logic [1:0] e_stat, input logic e_mis,
                        input logic [3:0] e_cnt, input bit inc);
        exp_t e;
        rst = r; stall = s; cnd = c; icode = ic; valC = vc; valM = vm; valP = vp;
        @(posedge clk);
        if (r) exp_ret = 0;
`ifdef PC_RETIRE_CNT_EN
        else if (inc) exp_ret = exp_ret + 1;
`endif
        e.pc = e_pc; e.stat = e_stat; e.mis = e_mis; e.cnt = e_cnt; e.ret = exp_ret;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; stall = 1'b0; cnd = 1'b0; icode = 4'd1;
        valC = '0; valM = '0; valP = '0;
        @(negedge clk);
        //   rst stall cnd icode valC      valM      valP      e_pc      stat mis cnt inc
        step(1, 0, 0, 4'd6, 64'h0,    64'h0,    64'h102,  64'h100,  0, 0, 0, 0);
        step(0, 0, 0, 4'd6, 64'h0,    64'h0,    64'h102,  64'h102,  0, 0, 0, 1);
        step(0, 0, 1, 4'd7, 64'h400,  64'h0,    64'h109,  64'h400,  0, 0, 0, 1);
        step(0, 0, 0, 4'd7, 64'h400,  64'h0,    64'h109,  64'h109,  0, 0, 0, 1);
        step(0, 1, 1, 4'd7, 64'h400,  64'h0,    64'h109,  64'h109,  0, 0, 0, 0);
        step(0, 0, 0, 4'd8, 64'h800,  64'h0,    64'h20A,  64'h800,  0, 0, 1, 1);
        step(0, 0, 0, 4'd9, 64'h0,    64'h20A,  64'h0,    64'h20A,  0, 0, 0, 1);
        step(0, 0, 0, 4'd8, 64'h800,  64'h0,    64'h20A,  64'h800,  0, 0, 1, 1);
        step(0, 0, 0, 4'd9, 64'h0,    64'h300,  64'h0,    64'h300,  0, 1, 0, 1);
        step(0, 0, 0, 4'd1, 64'h0,    64'h0,    64'h302,  64'h302,  0, 0, 0, 1);
        step(0, 0, 0, 4'd8, 64'h900,  64'h0,    64'h304,  64'h900,  0, 0, 1, 1);
        step(0, 1, 0, 4'd9, 64'h0,    64'hBAD,  64'h0,    64'h900,  0, 0, 1, 0);
        step(0, 0, 0, 4'd9, 64'h0,    64'h304,  64'h0,    64'h304,  0, 0, 0, 1);
        // nine calls overflow an 8-deep RAS; the oldest entry (0x10) is overwritten
        for (int i = 0; i < 9; i++)
            step(0, 0, 0, 4'd8, 64'h1000 + 64'(i), 64'h0, 64'h10 + 64'(i),
                 64'h1000 + 64'(i), 0, 0, (i < 8) ? 4'(i + 1) : 4'd8, 1);
        for (int j = 0; j < 8; j++)
            step(0, 0, 0, 4'd9, 64'h0, 64'h18 - 64'(j), 64'h0,
                 64'h18 - 64'(j), 0, 0, 4'(7 - j), 1);
        step(0, 0, 0, 4'd9, 64'h0,    64'h10,   64'h0,    64'h10,   0, 1, 0, 1);
        // halt freezes everything
        step(0, 0, 0, 4'd0, 64'h0,    64'h0,    64'h55,   64'h10,   1, 0, 0, 0);
        step(0, 0, 1, 4'd7, 64'h777,  64'h0,    64'h56,   64'h10,   1, 0, 0, 0);
        step(0, 0, 0, 4'd8, 64'h888,  64'h0,    64'h57,   64'h10,   1, 0, 0, 0);
        step(0, 0, 0, 4'd9, 64'h0,    64'h0,    64'h58,   64'h10,   1, 0, 0, 0);
        step(1, 0, 0, 4'd1, 64'h0,    64'h0,    64'h0,    64'h100,  0, 0, 0, 0);
        // reset discards RAS contents
        step(0, 0, 0, 4'd8, 64'h2000, 64'h0,    64'h2002, 64'h2000, 0, 0, 1, 1);
        step(1, 0, 0, 4'd1, 64'h0,    64'h0,    64'h0,    64'h100,  0, 0, 0, 0);
        step(0, 0, 0, 4'd9, 64'h0,    64'h2002, 64'h0,    64'h2002, 0, 1, 0, 1);
        step(0, 0, 0, 4'd12,64'h0,    64'h0,    64'h3000, 64'h2002, 2, 0, 0, 0);
        step(0, 0, 0, 4'd6, 64'h0,    64'h0,    64'h3002, 64'h2002, 2, 0, 0, 0);
        // retire count: 5 commits, 2 stalls, then halt
        step(1, 0, 0, 4'd1, 64'h0,    64'h0,    64'h0,    64'h100,  0, 0, 0, 0);
        step(0, 0, 0, 4'd6, 64'h0,    64'h0,    64'h101,  64'h101,  0, 0, 0, 1);
        step(0, 0, 0, 4'd6, 64'h0,    64'h0,    64'h102,  64'h102,  0, 0, 0, 1);
        step(0, 1, 0, 4'd6, 64'h0,    64'h0,    64'h1FF,  64'h102,  0, 0, 0, 0);
        step(0, 0, 0, 4'd6, 64'h0,    64'h0,    64'h103,  64'h103,  0, 0, 0, 1);
        step(0, 1, 0, 4'd0, 64'h0,    64'h0,    64'h1FF,  64'h103,  0, 0, 0, 0);
        step(0, 0, 0, 4'd6, 64'h0,    64'h0,    64'h104,  64'h104,  0, 0, 0, 1);
        step(0, 0, 0, 4'd6, 64'h0,    64'h0,    64'h105,  64'h105,  0, 0, 0, 1);
        step(0, 0, 0, 4'd0, 64'h0,    64'h0,    64'h106,  64'h105,  1, 0, 0, 0);
        step(0, 0, 0, 4'd6, 64'h0,    64'h0,    64'h107,  64'h105,  1, 0, 0, 0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
